// File: rtl/ct_f_spsram_rmw.sv
// Parametrised single-port SRAM wrapper with per-bit write mask via internal read-modify-write.
// Optional per-byte even parity storage and checking when CT_F_SPSRAM_PARITY_EN is defined.
module ct_f_spsram_rmw #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic                  READY,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVLD,
  output logic                  PERR
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
`ifdef CT_F_SPSRAM_PARITY_EN
  localparam int unsigned StoreWidth = DATA_WIDTH + NumBytes;
`else
  localparam int unsigned StoreWidth = DATA_WIDTH;
`endif

  typedef enum logic [0:0] {StIdle, StMerge} state_e;

  state_e                  state_q;
  logic                    ready_q;
  logic                    qvld_q;
  logic [ADDR_WIDTH-1:0]   a_cap_q;
  logic [DATA_WIDTH-1:0]   d_cap_q;
  logic [DATA_WIDTH-1:0]   wen_cap_q;
  logic [DATA_WIDTH-1:0]   hold_q;

  logic [StoreWidth-1:0]   mem [Depth];
  logic [StoreWidth-1:0]   rdata_q;

  logic                    accept;
  logic                    wen_all0;
  logic                    wen_all1;
  logic                    rd_req;
  logic                    full_wr;
  logic                    merge_wr;
  logic [DATA_WIDTH-1:0]   old_data;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [StoreWidth-1:0]   wr_word;

  assign accept   = !CEN && ready_q && !RST;
  assign wen_all0 = ~|WEN;
  assign wen_all1 = &WEN;
  // A partial write also reads the RAM so the old word is available in StMerge.
  assign rd_req   = accept && (GWEN || (!wen_all0 && !wen_all1));
  assign full_wr  = accept && !GWEN && wen_all0;
  assign merge_wr = (state_q == StMerge) && !RST;

  assign old_data = rdata_q[DATA_WIDTH-1:0];
  assign merged   = (d_cap_q & ~wen_cap_q) | (old_data & wen_cap_q);
  assign wr_data  = merge_wr ? merged : D;
  assign wr_addr  = merge_wr ? a_cap_q : A;

`ifdef CT_F_SPSRAM_PARITY_EN
  logic [NumBytes-1:0] par_gen;
  logic [NumBytes-1:0] par_chk;

  always_comb begin
    par_gen = '0;
    par_chk = '0;
    for (int i = 0; i < NumBytes; i++) begin
      par_gen[i] = ^wr_data[8*i +: 8];
      par_chk[i] = ^{rdata_q[DATA_WIDTH+i], rdata_q[8*i +: 8]};
    end
  end

  assign wr_word = {par_gen, wr_data};
  assign PERR    = (qvld_q || (state_q == StMerge)) && (|par_chk);
`else
  assign wr_word = wr_data;
  assign PERR    = 1'b0;
`endif

  // RAM array: never read and written in the same cycle, since StMerge blocks acceptance.
  always_ff @(posedge CLK) begin
    if (full_wr || merge_wr) begin
      mem[wr_addr] <= wr_word;
    end
    if (rd_req) begin
      rdata_q <= mem[A];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      qvld_q    <= 1'b0;
      hold_q    <= '0;
      a_cap_q   <= '0;
      d_cap_q   <= '0;
      wen_cap_q <= '0;
    end else begin
      qvld_q <= accept && GWEN;
      if (qvld_q) begin
        hold_q <= rdata_q[DATA_WIDTH-1:0];
      end
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (rd_req && !GWEN) begin
            a_cap_q   <= A;
            d_cap_q   <= D;
            wen_cap_q <= WEN;
            ready_q   <= 1'b0;
            state_q   <= StMerge;
          end
        end
        StMerge: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign READY = ready_q;
  assign QVLD  = qvld_q;
  assign Q     = qvld_q ? rdata_q[DATA_WIDTH-1:0] : hold_q;

endmodule

// File: tb/tb_ct_f_spsram_rmw.sv
// Directed self-checking bench for ct_f_spsram_rmw: reset, full/partial/masked writes,
// back-to-back traffic, reset during merge and (with CT_F_SPSRAM_PARITY_EN) parity errors.
module tb_ct_f_spsram_rmw;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 128;

  logic          CLK;
  logic          RST;
  logic          CEN;
  logic          GWEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] WEN;
  logic          READY;
  logic [DW-1:0] Q;
  logic          QVLD;
  logic          PERR;

  int n_err = 0;
  int n_chk = 0;

  ct_f_spsram_rmw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .CEN  (CEN),
    .GWEN (GWEN),
    .A    (A),
    .D    (D),
    .WEN  (WEN),
    .READY(READY),
    .Q    (Q),
    .QVLD (QVLD),
    .PERR (PERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    CEN  = 1'b1;
    GWEN = 1'b1;
  endtask

  // Issue one write and wait (bounded) until the wrapper is ready again.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] wen);
    CEN = 1'b0; GWEN = 1'b0; A = a; D = d; WEN = wen;
    tick();
    go_idle();
    for (int i = 0; i < 4 && !READY; i++) tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input logic exp_perr, input string name);
    CEN = 1'b0; GWEN = 1'b1; A = a;
    tick();
    go_idle();
    n_chk++;
    if (QVLD !== 1'b1) begin
      n_err++; $display("FAIL %s_qvld: got %b want 1", name, QVLD);
    end
    n_chk++;
    if (Q !== exp) begin
      n_err++; $display("FAIL %s_q: got %h want %h", name, Q, exp);
    end
    n_chk++;
    if (PERR !== exp_perr) begin
      n_err++; $display("FAIL %s_perr: got %b want %b", name, PERR, exp_perr);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    go_idle();
    A = '0; D = '0; WEN = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (READY !== 1'b0 || QVLD !== 1'b0 || PERR !== 1'b0) begin
        n_err++;
        $display("FAIL rst_hold: got ready=%b qvld=%b perr=%b want 0 0 0", READY, QVLD, PERR);
      end
    end
    RST = 1'b0;
    tick();
    n_chk++;
    if (READY !== 1'b1) begin
      n_err++; $display("FAIL rst_ready: got %b want 1", READY);
    end
    n_chk++;
    if (Q !== '0) begin
      n_err++; $display("FAIL rst_q: got %h want 0", Q);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp;
    exp = {16{8'hA5}};
    do_write(12'h005, exp, '0);
    do_read(12'h005, exp, 1'b0, "wr_rd");
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (Q !== exp || QVLD !== 1'b0) begin
        n_err++; $display("FAIL q_hold%0d: got q=%h qvld=%b want %h 0", i, Q, QVLD, exp);
      end
    end
  endtask

  task automatic test_partial();
    logic [DW-1:0] pre;
    logic [DW-1:0] exp;
    pre = {2{64'h0123456789ABCDEF}};
    exp = {64'h0123456789ABCDEF, 64'h0123456789ABCDFF};
    do_write(12'h010, pre, '0);
    CEN = 1'b0; GWEN = 1'b0; A = 12'h010; D = '1; WEN = {{(DW-8){1'b1}}, 8'h00};
    tick();
    go_idle();
    n_chk++;
    if (READY !== 1'b0) begin
      n_err++; $display("FAIL part_busy: got ready=%b want 0", READY);
    end
    tick();
    n_chk++;
    if (READY !== 1'b1) begin
      n_err++; $display("FAIL part_ready: got ready=%b want 1", READY);
    end
    do_read(12'h010, exp, 1'b0, "part");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1;
    logic [DW-1:0] exp2;
    d1   = {4{32'hDEADBEEF}};
    exp2 = {{8{8'hCC}}, {8{8'h33}}};
    do_write(12'h002, {16{8'h33}}, '0);
    CEN = 1'b0; GWEN = 1'b0; A = 12'h001; D = d1; WEN = '0;
    tick();
    n_chk++;
    if (READY !== 1'b1 || QVLD !== 1'b0) begin
      n_err++; $display("FAIL b2b_w1: got ready=%b qvld=%b want 1 0", READY, QVLD);
    end
    GWEN = 1'b1; A = 12'h001;
    tick();
    n_chk++;
    if (QVLD !== 1'b1 || Q !== d1 || READY !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_r1: got qvld=%b q=%h ready=%b want 1 %h 1", QVLD, Q, READY, d1);
    end
    GWEN = 1'b0; A = 12'h002; D = {16{8'hCC}}; WEN = {{64{1'b0}}, {64{1'b1}}};
    tick();
    n_chk++;
    if (READY !== 1'b0 || QVLD !== 1'b0 || Q !== d1) begin
      n_err++;
      $display("FAIL b2b_pw: got ready=%b qvld=%b q=%h want 0 0 %h", READY, QVLD, Q, d1);
    end
    GWEN = 1'b1; A = 12'h002;
    tick();
    n_chk++;
    if (READY !== 1'b1 || QVLD !== 1'b0) begin
      n_err++; $display("FAIL b2b_merge: got ready=%b qvld=%b want 1 0", READY, QVLD);
    end
    tick();
    go_idle();
    n_chk++;
    if (QVLD !== 1'b1 || Q !== exp2) begin
      n_err++; $display("FAIL b2b_r2: got qvld=%b q=%h want 1 %h", QVLD, Q, exp2);
    end
  endtask

  task automatic test_masked_off();
    logic [DW-1:0] exp;
    exp = {64'h0123456789ABCDEF, 64'h0123456789ABCDFF};
    CEN = 1'b0; GWEN = 1'b0; A = 12'h010; D = '0; WEN = '1;
    tick();
    go_idle();
    n_chk++;
    if (READY !== 1'b1 || QVLD !== 1'b0) begin
      n_err++; $display("FAIL mask_ready: got ready=%b qvld=%b want 1 0", READY, QVLD);
    end
    do_read(12'h010, exp, 1'b0, "mask");
  endtask

  task automatic test_reset_mid_rmw();
    logic [DW-1:0] pre;
    pre = {16{8'h55}};
    do_write(12'h020, pre, '0);
    CEN = 1'b0; GWEN = 1'b0; A = 12'h020; D = '0; WEN = {{(DW-8){1'b1}}, 8'h00};
    tick();
    go_idle();
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (QVLD !== 1'b0 || READY !== 1'b0) begin
        n_err++; $display("FAIL rmw_rst%0d: got qvld=%b ready=%b want 0 0", i, QVLD, READY);
      end
    end
    RST = 1'b0;
    tick();
    do_read(12'h020, pre, 1'b0, "rmw_rst");
  endtask

`ifdef CT_F_SPSRAM_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] pre;
    logic [DW-1:0] bad;
    logic [DW-1:0] exp;
    pre = {4{32'h13579BDF}};
    bad = pre ^ 128'h8;
    exp = {pre[DW-1:8], 8'h5A};
    do_write(12'h030, pre, '0);
    dut.mem[12'h030][3] = ~dut.mem[12'h030][3];
    do_read(12'h030, bad, 1'b1, "par_bad");
    CEN = 1'b0; GWEN = 1'b0; A = 12'h030; D = {16{8'h5A}}; WEN = {{(DW-8){1'b1}}, 8'h00};
    tick();
    go_idle();
    n_chk++;
    if (PERR !== 1'b1 || READY !== 1'b0) begin
      n_err++; $display("FAIL par_merge: got perr=%b ready=%b want 1 0", PERR, READY);
    end
    tick();
    do_read(12'h030, exp, 1'b0, "par_fix");
  endtask
`endif

  initial begin
    go_idle();
    RST = 1'b1; A = '0; D = '0; WEN = '1;
    test_reset();
    test_write_read();
    test_partial();
    test_back_to_back();
    test_masked_off();
    test_reset_mid_rmw();
`ifdef CT_F_SPSRAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_rmw.md
# ct_f_spsram_rmw

Parametrised FPGA single-port SRAM wrapper for C910 FPGA builds. It replaces the fixed-geometry, word-write-only wrappers with a configurable-depth and configurable-width macro that honours the full per-bit write mask. It sits between core array controllers (cache data/tag arrays, buffers) and the inferred block RAM (`fpga_ram`). Partial-mask writes are implemented as an internal two-cycle read-modify-write with a ready handshake. Read data is held stable until the next read completes.

## Interface
- ADDR_WIDTH, 12, address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 128, data bits per word; must be a multiple of 8.

- CLK  input  1  single clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- CEN  input  1  chip enable, active low.
- GWEN  input  1  global write enable, active low; 1 = read.
- A  input  ADDR_WIDTH  word address.
- D  input  DATA_WIDTH  write data.
- WEN  input  DATA_WIDTH  per-bit write enable, active low (0 = write that bit).
- READY  output  1  request accepted this cycle when high.
- Q  output  DATA_WIDTH  read data.
- QVLD  output  1  one-cycle pulse: Q carries new read data.
- PERR  output  1  parity error pulse (see Configuration).

## Operation
- Accept: a request is accepted on a rising edge where !CEN && READY && !RST. Requests while READY=0 are ignored; the master holds them until READY=1.
- Read (GWEN=1): the RAM is addressed with A. QVLD=1 in the next cycle, and Q = RAM output in that cycle. The Q value is captured into a hold register; afterwards Q = hold register until the next QVLD.
- Full write (GWEN=0, WEN all 0): D is written in the acceptance cycle. READY stays 1. Q and QVLD are unchanged.
- Masked-off write (GWEN=0, WEN all 1): no RAM write. Treated as a completed no-op; READY stays 1.
- Partial write (GWEN=0, WEN mixed): an FSM with two states.
  - IDLE: accept. Capture A, D and WEN. Issue a RAM read of A. Go to MERGE.
  - MERGE: READY=0. Compute merged = (D_cap & ~WEN_cap) | (old & WEN_cap). Write merged to A_cap. Return to IDLE.
  - Q and QVLD are unaffected by the internal read.
- Throughput: 1 read or full write per cycle; 1 partial write per 2 cycles.
- When the RAM is idle (CEN=1), the RAM address holds its last value.
- Reset values: READY=0 while RST=1, and 1 from the first cycle after release. Q=0, QVLD=0, PERR=0, FSM=IDLE, captured registers=0. RAM contents are not initialised.
- Reset during MERGE: the merge write is suppressed and the stored word keeps its old value.
- No forwarding is needed. READY=0 during MERGE guarantees that any later request sees committed data.

## Timing
- Read latency: 1 cycle. Read accepted at edge N gives QVLD/Q valid in cycle N+1 (sampled at edge N+1).
- Full write at edge N: a read accepted at edge N+1 to the same address returns the new data.
- Partial write accepted at edge N: READY=0 in cycle N+1; the merge commits at edge N+1. A read accepted at edge N+2 returns the merged word.
- Back-to-back reads: QVLD stays high continuously, and Q updates every cycle.
- Q never changes except in a QVLD cycle or on reset.

## Configuration
- CT_F_SPSRAM_PARITY_EN defined:
  - Storage width becomes DATA_WIDTH + DATA_WIDTH/8.
  - Even parity per byte is generated on every write, including merged words.
  - Parity is checked on user reads; PERR=1 in the QVLD cycle if any byte mismatches.
  - Parity is also checked on the old word in MERGE; PERR pulses in the MERGE cycle. The merge write still proceeds with regenerated parity.
- CT_F_SPSRAM_PARITY_EN undefined: storage width = DATA_WIDTH; PERR is tied to 0.

## Test plan
- Reset then read: RST high 3 cycles, then release. Expect READY=1 and Q=0. Write A=0x005 D=all 0xA5 WEN=0, then read A=0x005. Expect QVLD in the next cycle with Q=0xA5…A5, held constant for 5 idle cycles.
- Partial write: preload A=0x010 with 0x0123…CDEF. Write D=all 1s, WEN=0xFFFF…FF00 (low byte enabled). Expect READY=0 for exactly one cycle. A read returns 0x0123…CDFF.
- Back-to-back mix: issue full write A=1, read A=1, partial write A=2, read A=2 on consecutive accepted cycles. Expect correct data, READY low only in the cycle after the partial write, and QVLD only for the reads.
- Masked-off write: GWEN=0, WEN all 1s, D=0 to a preloaded address. Expect READY to stay 1 and the contents to be unchanged on readback.
- Reset mid-RMW: assert RST in the MERGE cycle of a partial write to A=0x020 holding 0x55…55. After reset, a read returns 0x55…55 and QVLD=0 during reset.
- Parity (macro defined): force-flip one stored bit of A=0x030 via backdoor, then read. Expect PERR=1 coincident with QVLD. A partial write to the same address pulses PERR in MERGE; a subsequent read returns PERR=0.
